// File: rtl/usb_rx_phy_pkg.sv
// Shared types and constants for the low-speed USB receive front end.
package usb_rx_phy_pkg;

  localparam int unsigned CLK_PER_BIT_LS  = 16;
  localparam int unsigned USB_STUFF_LIMIT = 6;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  // Raw pad pair as sampled: dp is bit 1, dm is bit 0.
  typedef struct packed {
    logic dp;
    logic dm;
  } d_port_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } rx_state_t;

endpackage

// File: rtl/usb_dpll.sv
// Bit-clock recovery: phase counter realigned on every line-state change,
// strobing once per bit at mid-bit.
module usb_dpll
  import usb_rx_phy_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_LS
) (
  input  logic        clk,
  input  logic        reset,
  input  line_state_t line_state,
  output logic        bit_strobe
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  line_state_t   prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] phase_c;
  logic [CW-1:0] cnt_next_c;

  // The cycle that shows a new line state is phase 0 of the new bit.
  always_comb begin
    phase_c    = (line_state != prev) ? '0 : cnt;
    cnt_next_c = (phase_c == LAST) ? '0 : phase_c + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= J;
      cnt        <= '0;
      bit_strobe <= 1'b0;
    end else begin
      prev       <= line_state;
      cnt        <= cnt_next_c;
      bit_strobe <= (cnt_next_c == HALF);
    end
  end

endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: synchroniser, line decode, NRZI decode,
// SYNC hunt, bit unstuffing and byte assembly with framing strobes.
module usb_rx_phy
  import usb_rx_phy_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT    = CLK_PER_BIT_LS,
  parameter int unsigned SYNC_MIN_ZEROS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  d_port_t     d_i,
  output line_state_t line_state,
  output logic        rx_active,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_error
);

  localparam int unsigned ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam logic [ZW-1:0] ZMAX  = ZW'(SYNC_MIN_ZEROS);
  localparam logic [2:0]    STUFF = 3'(USB_STUFF_LIMIT);
  localparam d_port_t       D_IDLE = '{dp: 1'b0, dm: 1'b1};

  d_port_t     sync1;
  d_port_t     sync2;
  logic        bit_strobe;
  logic        decoded_c;
  rx_state_t   state;
  line_state_t prev_sample;
  logic [ZW-1:0] zeros;
  logic [2:0]  ones;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;

  // Two-flop synchroniser, then the registered line state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= D_IDLE;
      sync2      <= D_IDLE;
      line_state <= J;
    end else begin
      sync1      <= d_i;
      sync2      <= sync1;
      line_state <= line_state_t'({sync2.dp, sync2.dm});
    end
  end

  usb_dpll #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_dpll (
    .clk        (clk),
    .reset      (reset),
    .line_state (line_state),
    .bit_strobe (bit_strobe)
  );

  // NRZI: no change between mid-bit samples is a 1.
  assign decoded_c = (line_state == prev_sample);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_sample <= J;
      zeros       <= '0;
      ones        <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_active   <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      rx_error    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (bit_strobe) begin
        prev_sample <= line_state;
        case (state)
          ST_IDLE: begin
            if (line_state == K) begin
              state <= ST_HUNT;
              zeros <= ZW'(1);
            end
          end
          ST_HUNT: begin
            if (line_state == SE0) begin
              state <= ST_IDLE;
            end else if (!decoded_c) begin
              if (zeros != ZMAX) zeros <= zeros + ZW'(1);
            end else if (zeros == ZMAX) begin
              state     <= ST_DATA;
              rx_active <= 1'b1;
              ones      <= 3'd1;
              bit_cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (line_state == SE0) begin
              state <= ST_EOP;
              if (bit_cnt != 3'd0) rx_error <= 1'b1;
            end else if (line_state == SE1) begin
              state    <= ST_ERROR;
              rx_error <= 1'b1;
            end else if (ones == STUFF) begin
              // Bit after six ones must be a stuffed zero and is dropped.
              ones <= '0;
              if (decoded_c) begin
                state    <= ST_ERROR;
                rx_error <= 1'b1;
              end
            end else begin
              shreg   <= {decoded_c, shreg[6:1]};
              ones    <= decoded_c ? ones + 3'd1 : 3'd0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {decoded_c, shreg};
                rx_valid <= 1'b1;
              end
            end
          end
          ST_EOP: begin
            if (line_state == J) begin
              state     <= ST_IDLE;
              rx_active <= 1'b0;
            end
          end
          ST_ERROR: begin
            if (line_state == SE0) state <= ST_EOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
